proc_fetch_decode: RTL
======================

# proc_fetch_decode

Parametrised instruction fetch/decode front end for the `proc` core. It holds a `PROG_DEPTH`-word program memory that is loaded over a write port while idle. It steps a program counter and registers each fetched word, split into `op_code`, source/destination addresses and choice fields, for the execute stage. It generalises the fixed-width decode inside `proc`: widths, depth and halt opcode are parameters, and it adds stall, taken-jump redirect with flush, and halt detection.

## Interface
- `OPCODE_WIDTH`, 6: opcode field width.
- `MEM_WIDTH`, 8: width of each address field.
- `PROG_DEPTH`, 64: program words; must be a power of two, ≥2.
- `HALT_OP`, all ones: opcode that stops fetching.
- Derived: `PC_W = $clog2(PROG_DEPTH)`; `INSTR_W = OPCODE_WIDTH + 3*(2+MEM_WIDTH)`.
- Word layout, MSB to LSB: `op_code`, `dest_choice`, `dest_addr`, `source1_choice`, `source1_addr`, `source2_choice`, `source2_addr`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write `load_data` to `mem[load_addr]`.
- `load_addr`  in  PC_W  program write address.
- `load_data`  in  INSTR_W  program word.
- `load_err`  out  1  one-cycle pulse: load attempted outside IDLE.
- `run`  in  1  level; start in IDLE, return to IDLE from HALTED when low.
- `stall`  in  1  execute stage not ready; freeze PC and outputs.
- `jump_en`  in  1  taken branch from execute.
- `jump_addr`  in  PC_W  branch target.
- `pc`  out  PC_W  address of the next word to fetch.
- `instr_valid`  out  1  decoded fields below are a live instruction.
- `op_code`  out  OPCODE_WIDTH  decoded opcode.
- `source1_addr`, `source2_addr`, `dest_addr`  out  MEM_WIDTH each  decoded operand addresses.
- `source1_choice`, `source2_choice`, `dest_choice`  out  2 each  decoded operand selectors.
- `halted`  out  1  high in HALTED.

## Operation
- FSM states are IDLE, RUN and HALTED. Reset (`rst`=0) forces IDLE immediately.
- Reset values: `pc`=0; `instr_valid`=0; `halted`=0; `load_err`=0; all decoded fields 0. Program memory is not reset.
- IDLE:
  - `load_en`=1 writes memory at the edge.
  - `run`=1 moves to RUN with `pc`=0.
  - If `load_en` and `run` are both high in the same cycle, the write is performed, then RUN is entered.
- RUN, evaluated per edge in priority order:
  1. `jump_en`=1: `pc`←`jump_addr`, `instr_valid`←0 (one-cycle flush bubble). Applies even when `stall`=1.
  2. `stall`=1: `pc`, `instr_valid` and all fields hold.
  3. Otherwise: output registers ←`mem[pc]` split into fields, `instr_valid`←1, `pc`←`pc+1` mod `PROG_DEPTH`. The last address wraps to 0.
  - If the captured opcode equals `HALT_OP`, the halt word is presented with `instr_valid`=1 for one cycle and the state moves to HALTED. `pc` does not advance past the halt word.
  - `load_en` in RUN or HALTED: memory unchanged, `load_err` pulses next cycle.
  - `run` deasserting in RUN has no effect; only the halt opcode stops fetching.
- HALTED:
  - `halted`=1, `instr_valid`=0, fields hold the last value.
  - `stall` and `jump_en` are ignored.
  - `run`=0 moves to IDLE and resets `pc` to 0.
- Memory read is combinational from the array; the output fields are registered. This is the only pipeline stage.

## Timing
- `run` high in IDLE at edge k puts the block in RUN. `mem[0]` is on the outputs with `instr_valid`=1 after edge k+1, `mem[1]` after edge k+2, and so on: one instruction per unstalled cycle.
- Latency from PC to output is 1 cycle.
- `jump_en` at edge j gives `instr_valid`=0 after j, and `mem[jump_addr]` with valid after j+1.
- A jump to the current `pc` value is legal and re-fetches that word.
- `stall` is sampled each edge. During a stall the outputs are stable, so the consumer sees the same instruction repeated, not duplicated.
- A halt word captured at edge h sets `halted`=1 after h+1, with `instr_valid`=0 from then on.
- A load in IDLE is visible to a fetch on the following edge.
- Reset asserted mid-RUN clears all outputs asynchronously, with no wait for `clk`. The first RUN after reset release starts at address 0.

## Test plan
- Load words 0..3 with opcodes 1,2,3,`HALT_OP`, then pulse `run` → opcodes 1,2,3,`HALT_OP` valid on 4 consecutive cycles, then `halted`=1, `instr_valid`=0, `pc`=3.
- With `PROG_DEPTH`=4 and no halt word, run → sequence 0,1,2,3,0,1 with `pc` wrapping 3→0.
- Assert `stall` for 3 cycles while word 1 is presented → fields and `pc` frozen for 3 cycles, then word 2 follows.
- At word 2, assert `jump_en` with `jump_addr`=0 together with `stall`=1 → one bubble (`instr_valid`=0), then word 0 valid.
- Issue `load_en` during RUN with `load_data`=0x5A → `load_err` pulses once; after halt and a return to IDLE, the original word is still fetched.
- Drop `rst` asynchronously between edges mid-RUN → all outputs 0 before the next edge. After release with `run`=1, fetch restarts from word 0.

Source files
------------

// File: rtl/proc_fetch_decode.sv
// rtl/proc_fetch_decode.sv - instruction fetch/decode front end with program memory, stall, jump flush and halt
module proc_fetch_decode #(
  parameter int OPCODE_WIDTH = 6,
  parameter int MEM_WIDTH = 8,
  parameter int PROG_DEPTH = 64,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OP = '1,
  parameter int PC_W = $clog2(PROG_DEPTH),
  parameter int INSTR_W = OPCODE_WIDTH + 3*(2+MEM_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [PC_W-1:0]         load_addr,
  input  logic [INSTR_W-1:0]      load_data,
  output logic                    load_err,
  input  logic                    run,
  input  logic                    stall,
  input  logic                    jump_en,
  input  logic [PC_W-1:0]         jump_addr,
  output logic [PC_W-1:0]         pc,
  output logic                    instr_valid,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [MEM_WIDTH-1:0]    source1_addr,
  output logic [MEM_WIDTH-1:0]    source2_addr,
  output logic [MEM_WIDTH-1:0]    dest_addr,
  output logic [1:0]              source1_choice,
  output logic [1:0]              source2_choice,
  output logic [1:0]              dest_choice,
  output logic                    halted
);

  localparam int FIELD_W = 2 + MEM_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t               state, state_nx;
  logic [INSTR_W-1:0]   mem [PROG_DEPTH];
  logic [INSTR_W-1:0]   instr_q;
  logic [INSTR_W-1:0]   fetch_word;
  logic [PC_W-1:0]      pc_nx;
  logic                 valid_nx;
  logic                 err_nx;
  logic                 capture;
  logic                 mem_we;
  logic                 fetch_is_halt;
  logic                 cur_is_halt;

  assign fetch_word    = mem[pc];
  assign fetch_is_halt = (fetch_word[INSTR_W-1 -: OPCODE_WIDTH] == HALT_OP);
  // The halt word spends exactly one cycle on the outputs before HALTED is entered.
  assign cur_is_halt   = instr_valid && (op_code == HALT_OP);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    valid_nx = instr_valid;
    err_nx   = 1'b0;
    capture  = 1'b0;
    mem_we   = 1'b0;
    case (state)
      S_IDLE: begin
        mem_we   = load_en;
        valid_nx = 1'b0;
        if (run) begin
          state_nx = S_RUN;
          pc_nx    = '0;
        end
      end
      S_RUN: begin
        err_nx = load_en;
        if (cur_is_halt) begin
          state_nx = S_HALTED;
          valid_nx = 1'b0;
        end else if (jump_en) begin
          pc_nx    = jump_addr;
          valid_nx = 1'b0;
        end else if (!stall) begin
          capture  = 1'b1;
          valid_nx = 1'b1;
          if (!fetch_is_halt) pc_nx = pc + PC_W'(1);
        end
      end
      S_HALTED: begin
        err_nx   = load_en;
        valid_nx = 1'b0;
        if (!run) begin
          state_nx = S_IDLE;
          pc_nx    = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        pc_nx    = '0;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      instr_valid <= 1'b0;
      load_err    <= 1'b0;
      instr_q     <= '0;
    end else begin
      pc          <= pc_nx;
      instr_valid <= valid_nx;
      load_err    <= err_nx;
      if (capture) instr_q <= fetch_word;
    end
  end

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  assign op_code        = instr_q[INSTR_W-1 -: OPCODE_WIDTH];
  assign dest_choice    = instr_q[3*FIELD_W-1 -: 2];
  assign dest_addr      = instr_q[3*FIELD_W-3 -: MEM_WIDTH];
  assign source1_choice = instr_q[2*FIELD_W-1 -: 2];
  assign source1_addr   = instr_q[2*FIELD_W-3 -: MEM_WIDTH];
  assign source2_choice = instr_q[FIELD_W-1 -: 2];
  assign source2_addr   = instr_q[MEM_WIDTH-1:0];
  assign halted         = (state == S_HALTED);

endmodule
